// File: rtl/press_classifier.sv
// Purpose: classify a debounced button gesture as a short press, long press or double click.
// Latency: registered outputs; each pulse appears one cycle after its deciding condition.
// Backpressure: none; the pulses are single-cycle events that must be consumed when they occur.
module press_classifier #(
    parameter int LONG_CYC = 50_000_000,
    parameter int GAP_CYC  = 12_500_000,
    parameter int CW       = 26
) (
    input  logic clk,
    input  logic reset_n,
    input  logic db_level,
    input  logic db_tick,
    output logic short_tick,
    output logic long_tick,
    output logic double_tick,
    output logic held,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        LONG   = 3'd2,
        GAP    = 3'd3,
        PRESS2 = 3'd4
    } state_t;

    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // Previous-cycle button level, used only to spot the release edge.
    logic          lvl_q;
    logic          short_q, short_d;
    logic          long_q, long_d;
    logic          double_q, double_d;
    logic          held_q, held_d;
    logic          busy_q, busy_d;
    logic          fall;

    assign fall = lvl_q & ~db_level;

    // Next-state, counter and output-pulse decisions for the gesture FSM.
    always_comb begin
        state_d  = state_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (db_tick) state_d = PRESS1;
            end
            PRESS1: begin
                // A release on the threshold cycle still counts as a short press.
                if (fall) begin
                    state_d = GAP;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                end
            end
            LONG: begin
                if (fall) state_d = IDLE;
            end
            GAP: begin
                // A re-press on the timeout cycle still makes a double click.
                if (db_tick) begin
                    state_d  = PRESS2;
                    double_d = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                end
            end
            PRESS2: begin
                if (fall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Counter restarts on every state change and only runs while timing a window.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == PRESS1 || state_q == GAP) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = '0;
        end

        held_d = (state_d == LONG);
        busy_d = (state_d != IDLE);
    end

    // State, counter, level history and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            lvl_q    <= 1'b0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            held_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lvl_q    <= db_level;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
            held_q   <= held_d;
            busy_q   <= busy_d;
        end
    end

    assign short_tick  = short_q;
    assign long_tick   = long_q;
    assign double_tick = double_q;
    assign held        = held_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_press_classifier.sv
// Purpose: randomized and directed gestures checked cycle by cycle against an event-time model.
// Latency: expected outputs are placed at absolute cycle numbers computed from the gesture timing.
// Backpressure: not applicable; the bench drives one input set per cycle.
module tb_press_classifier;

    localparam int L    = 20;
    localparam int G    = 10;
    localparam int NMAX = 4096;

    logic clk;
    logic reset_n;
    logic db_level;
    logic db_tick;
    logic short_tick;
    logic long_tick;
    logic double_tick;
    logic held;
    logic busy;

    press_classifier #(.LONG_CYC(L), .GAP_CYC(G), .CW(5)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .db_level    (db_level),
        .db_tick     (db_tick),
        .short_tick  (short_tick),
        .long_tick   (long_tick),
        .double_tick (double_tick),
        .held        (held),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle stimulus and expected outputs; cycle c spans posedge c to posedge c+1.
    logic stim_tick [NMAX];
    logic stim_lvl  [NMAX];
    logic stim_rst  [NMAX];
    logic exp_short [NMAX];
    logic exp_long  [NMAX];
    logic exp_dbl   [NMAX];
    logic exp_held  [NMAX];
    logic exp_busy  [NMAX];

    int t;
    int n_cmp;
    int n_bad;

    task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got {short,long,dbl,held,busy}=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic set_busy(input int a, input int b);
        for (int i = a; i <= b; i++) exp_busy[i] = 1'b1;
    endtask

    // kind 0: short press, 1: long press, 2: double click (d = release-to-retick, p2 = second hold),
    // 3: reset while in the first press (d = counter value at which reset is applied).
    task automatic add_gesture(input int kind, input int p1, input int d, input int p2);
        int t0, f, t2, f2, r, e;
        t0 = t;
        stim_tick[t0] = 1'b1;
        for (int i = 1; i <= p1; i++) stim_lvl[t0 + i] = 1'b1;
        f = t0 + p1 + 1;
        e = f;
        case (kind)
            0: begin
                exp_short[f + G + 1] = 1'b1;
                set_busy(t0 + 1, f + G);
                e = f + G;
            end
            1: begin
                exp_long[t0 + L + 1] = 1'b1;
                for (int i = t0 + L + 1; i <= f; i++) exp_held[i] = 1'b1;
                set_busy(t0 + 1, f);
                e = f;
            end
            2: begin
                t2 = f + d;
                stim_tick[t2] = 1'b1;
                exp_dbl[t2 + 1] = 1'b1;
                for (int i = 1; i <= p2; i++) stim_lvl[t2 + i] = 1'b1;
                f2 = t2 + p2 + 1;
                set_busy(t0 + 1, f2);
                e = f2;
            end
            default: begin
                r = t0 + 1 + d;
                stim_rst[r] = 1'b0;
                set_busy(t0 + 1, r);
                e = (r > f) ? r : f;
            end
        endcase
        t = e + 1 + int'($urandom_range(0, 3));
    endtask

    initial begin
        int kind, p1, d, p2, n_cyc;
        n_cmp = 0;
        n_bad = 0;
        reset_n  = 1'b0;
        db_level = 1'b0;
        db_tick  = 1'b0;
        for (int i = 0; i < NMAX; i++) begin
            stim_tick[i] = 1'b0; stim_lvl[i] = 1'b0; stim_rst[i] = 1'b1;
            exp_short[i] = 1'b0; exp_long[i] = 1'b0; exp_dbl[i]  = 1'b0;
            exp_held[i]  = 1'b0; exp_busy[i] = 1'b0;
        end
        stim_rst[0] = 1'b0;
        stim_rst[1] = 1'b0;
        t = 3;

        // Directed boundary cases first.
        add_gesture(0, 5, 0, 0);        // plain short press
        add_gesture(1, 40, 0, 0);       // long press held well past threshold
        add_gesture(2, 5, 4, 3);        // double click, re-tick 4 cycles after release
        add_gesture(2, 5, G, 2);        // re-tick exactly on the timeout cycle
        add_gesture(3, 25, 15, 0);      // reset at cnt=15 in the first press
        add_gesture(0, 5, 0, 0);        // normal classification after that reset
        add_gesture(0, L - 1, 0, 0);    // release on the long-threshold cycle
        add_gesture(1, L, 0, 0);        // shortest long press

        // Random gestures.
        while (t < NMAX - 200) begin
            kind = int'($urandom_range(0, 3));
            p2 = 0;
            d  = 0;
            case (kind)
                0: p1 = int'($urandom_range(1, L - 1));
                1: p1 = int'($urandom_range(L, L + 15));
                2: begin
                    p1 = int'($urandom_range(1, L - 1));
                    d  = int'($urandom_range(1, G));
                    p2 = int'($urandom_range(1, 30));
                end
                default: begin
                    d  = int'($urandom_range(0, L - 2));
                    p1 = d + int'($urandom_range(0, 12));
                end
            endcase
            add_gesture(kind, p1, d, p2);
        end
        n_cyc = t + 20;

        for (int c = 0; c < n_cyc; c++) begin
            @(posedge clk);
            #1;
            reset_n  = stim_rst[c];
            db_tick  = stim_tick[c];
            db_level = stim_lvl[c];
            @(negedge clk);
            check_eq($sformatf("cyc%0d", c),
                     {short_tick, long_tick, double_tick, held, busy},
                     {exp_short[c], exp_long[c], exp_dbl[c], exp_held[c], exp_busy[c]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
